// File: rtl/sobel_pkg.sv
`default_nettype none
// sobel_pkg -- pixel format, default frame geometry and FSM encoding shared by reader and writer blocks.
// Revision 1.0
package sobel_pkg;

  localparam int PIX_W          = 8;
  localparam int DEF_IMG_WIDTH  = 192;
  localparam int DEF_IMG_HEIGHT = 251;
  localparam int DEF_PIX_COUNT  = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;
  localparam int DEF_ADDR_W     = 16;
  localparam int ENTRY_W        = PIX_W + 2;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             eol;
    logic             eof;
  } pix_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

  // Counter width that stays legal for a dimension of 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_skid_fifo.sv
`default_nettype none
// pixel_skid_fifo -- 2-entry FIFO of pixel+eol+eof; the head entry is a register driving the stream directly.
// Revision 1.0
module pixel_skid_fifo
  import sobel_pkg::*;
(
  input  logic       clka,
  input  logic       reset,
  input  logic       push,
  input  pix_entry_t din,
  input  logic       pop,
  output pix_entry_t dout,
  output logic       full,
  output logic       empty
);

  pix_entry_t head;
  pix_entry_t tail;
  logic [1:0] count;
  logic       do_pop;
  logic       do_push;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = head;

  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (empty) head <= din;
          else       tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Same occupancy; the queue just advances by one.
          if (count == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/output_bram_reader.sv
`default_nettype none
// output_bram_reader -- reads one frame from a BRAM port in raster order and streams it with eol/eof tags.
// Revision 1.0
module output_bram_reader
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clka,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done_rd,
  output logic              ena_rd,
  output logic [ADDR_W-1:0] addra_rd,
  input  logic [PIX_W-1:0]  douta_rd,
  output logic [PIX_W-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_eol,
  output logic              m_eof
);

  localparam int                XW     = cnt_w(IMG_WIDTH);
  localparam int                YW     = cnt_w(IMG_HEIGHT);
  localparam logic [XW-1:0]     X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);

  rd_state_t  state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic       pend;
  logic       pend_eol;
  logic       pend_eof;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic [1:0] occ;
  logic [1:0] committed;
  pix_entry_t push_entry;
  pix_entry_t head;

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign occ     = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);

  // A pixel presented with m_ready high is certain to leave at the coming edge,
  // so its slot counts as free; this keeps one read per cycle under full flow.
  assign committed = occ + {1'b0, pend} - {1'b0, pop};
  assign ena_rd    = (state == ST_READ) && (committed < 2'd2);

  assign push_entry = '{data: douta_rd, eol: pend_eol, eof: pend_eof};
  assign m_data     = head.data;
  assign m_eol      = head.eol;
  assign m_eof      = head.eof;

  pixel_skid_fifo u_fifo (
    .clka  (clka),
    .reset (reset),
    .push  (pend),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done_rd  <= 1'b0;
      addra_rd <= '0;
      x        <= '0;
      y        <= '0;
      pend     <= 1'b0;
      pend_eol <= 1'b0;
      pend_eof <= 1'b0;
    end else begin
      done_rd <= 1'b0;
      pend    <= ena_rd;
      if (ena_rd) begin
        pend_eol <= (x == X_LAST);
        pend_eof <= (x == X_LAST) && (y == Y_LAST);
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_READ;
            busy     <= 1'b1;
            addra_rd <= '0;
            x        <= '0;
            y        <= '0;
          end
        end
        ST_READ: begin
          if (ena_rd) begin
            if (addra_rd == A_LAST) state    <= ST_DRAIN;
            else                    addra_rd <= addra_rd + ADDR_W'(1);
            if (x == X_LAST) begin
              x <= '0;
              y <= y + YW'(1);
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (pop && head.eof) begin
            state   <= ST_DONE;
            busy    <= 1'b0;
            done_rd <= 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          addra_rd <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_output_bram_reader.sv
`default_nettype none
// tb_output_bram_reader -- randomized scoreboard bench: a 4x3 reader under several m_ready patterns plus a 1x1 reader.
module tb_output_bram_reader;

  localparam int W      = 4;
  localparam int H      = 3;
  localparam int N      = W * H;
  localparam int AW     = 8;
  localparam int LIMIT  = 300;
  localparam int FRAMES = 9;

  localparam int M_ONE    = 0;
  localparam int M_TOGGLE = 1;
  localparam int M_STALL  = 2;
  localparam int M_RAND   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, start, m_ready;
  logic          busy, done_rd, ena_rd, m_valid, m_eol, m_eof;
  logic [AW-1:0] addra_rd;
  logic [7:0]    douta_rd, m_data;

  logic          start1;
  logic          ready1 = 1'b1;
  logic          busy1, done1, ena1, valid1, eol1, eof1;
  logic [AW-1:0] addr1;
  logic [7:0]    dout1, data1;

  logic [7:0] mem [16];
  logic [7:0] mem1;

  output_bram_reader #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW)) dut (
    .clka(clk), .reset(reset_n), .start(start), .busy(busy), .done_rd(done_rd),
    .ena_rd(ena_rd), .addra_rd(addra_rd), .douta_rd(douta_rd), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_eol(m_eol), .m_eof(m_eof)
  );

  output_bram_reader #(.IMG_WIDTH(1), .IMG_HEIGHT(1), .ADDR_W(AW)) dut1 (
    .clka(clk), .reset(reset_n), .start(start1), .busy(busy1), .done_rd(done1),
    .ena_rd(ena1), .addra_rd(addr1), .douta_rd(dout1), .m_data(data1),
    .m_valid(valid1), .m_ready(ready1), .m_eol(eol1), .m_eof(eof1)
  );

  // BRAM models: data appears one cycle after an enabled read.
  always @(posedge clk) if (ena_rd) douta_rd <= mem[addra_rd[3:0]];
  always @(posedge clk) if (ena1)   dout1    <= mem1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int mode = M_ONE;
  int checks = 0;
  int errors = 0;
  int frames_done = 0;
  int frames1 = 0;
  int hs_count = 0;
  logic final_req = 1'b0;
  logic final_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Scoreboard / monitor, sampled on the falling edge.
  logic [9:0] exp_q [$];
  logic [9:0] q1 [$];
  logic [9:0] e;
  logic [9:0] prev_pix;
  logic       active = 1'b0, active1 = 1'b0;
  logic       done_next = 1'b0, done1_next = 1'b0, done_now, done1_now;
  logic       prev_stall = 1'b0;
  int         e0 = 0, exp_addr = 0, issued = 0, hs_frame = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("reset_outputs", {busy, done_rd, ena_rd, m_valid, m_eol, m_eof, addra_rd, m_data}, 32'd0);
      chk("reset_outputs_1x1", {busy1, done1, ena1, valid1, eol1, eof1, addr1, data1}, 32'd0);
      exp_q.delete();
      q1.delete();
      active     = 1'b0;
      active1    = 1'b0;
      done_next  = 1'b0;
      done1_next = 1'b0;
      prev_stall = 1'b0;
    end else begin
      done_now  = done_next;
      done_next = 1'b0;
      chk("done_rd", done_rd, done_now);
      chk("busy", busy, active && (cyc >= e0) && !done_now);

      if (active && cyc == e0)     chk("first_read", {ena_rd, addra_rd}, {1'b1, 8'd0});
      if (active && cyc == e0 + 1) chk("valid_after_e1", m_valid, 1'b0);
      if (active && cyc == e0 + 2) chk("valid_after_e2", m_valid, 1'b1);

      if (ena_rd) begin
        issued++;
        chk("rd_addr", addra_rd, exp_addr);
        chk("rd_addr_in_range", addra_rd <= AW'(N - 1), 1'b1);
        chk("rd_outstanding", (issued - hs_frame - int'(m_valid && m_ready)) <= 2, 1'b1);
        exp_addr++;
      end

      if (prev_stall) chk("stall_hold", {m_valid, m_data, m_eol, m_eof}, {1'b1, prev_pix});
      prev_stall = m_valid && !m_ready;
      prev_pix   = {m_data, m_eol, m_eof};

      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_pixel", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("pixel", {m_data, m_eol, m_eof}, e);
          hs_frame++;
          hs_count++;
          if (e[0]) begin
            done_next = 1'b1;
            if (mode == M_ONE) chk("frame_cycles", cyc + 1 - e0, N + 2);
          end
        end
      end

      if (active && cyc > e0 + LIMIT) begin
        chk("frame_timeout", 1'b1, 1'b0);
        active = 1'b0;
        exp_q.delete();
      end

      if (start && !active) begin
        active   = 1'b1;
        e0       = cyc + 1;
        exp_addr = 0;
        issued   = 0;
        hs_frame = 0;
        for (int i = 0; i < N; i++)
          exp_q.push_back({mem[i], (i % W) == W - 1, i == N - 1});
      end
      if (done_now) begin
        frames_done++;
        active = 1'b0;
      end

      // 1x1 reader
      done1_now  = done1_next;
      done1_next = 1'b0;
      chk("done_1x1", done1, done1_now);
      if (valid1 && ready1) begin
        if (q1.size() == 0) begin
          chk("extra_pixel_1x1", 1'b1, 1'b0);
        end else begin
          e = q1.pop_front();
          chk("pixel_1x1", {data1, eol1, eof1}, e);
          if (e[0]) done1_next = 1'b1;
        end
      end
      if (start1 && !active1) begin
        active1 = 1'b1;
        q1.push_back({mem1, 1'b1, 1'b1});
      end
      if (done1_now) begin
        frames1++;
        active1 = 1'b0;
      end

      if (final_req && !final_ack) begin
        chk("queue_empty", exp_q.size(), 0);
        chk("queue_empty_1x1", q1.size(), 0);
        chk("frame_count", frames_done, FRAMES);
        chk("frame_count_1x1", frames1, 1);
        final_ack = 1'b1;
      end
    end
  end

  // m_ready driver.
  int stall_left = 10;
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        M_ONE:    m_ready = 1'b1;
        M_TOGGLE: m_ready = ~m_ready;
        M_STALL: begin
          if (stall_left > 0) begin
            m_ready = 1'b0;
            if (m_valid) stall_left--;
          end else begin
            m_ready = 1'b1;
          end
        end
        default:  m_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (mode != M_STALL) stall_left = 10;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    for (int k = 0; k < LIMIT && frames_done < target; k++) @(posedge clk);
  endtask

  task automatic wait_hs(input int target);
    for (int k = 0; k < LIMIT && hs_count < target; k++) @(posedge clk);
  endtask

  task automatic run_frame(input int m);
    int f;
    mode = m;
    f = frames_done;
    pulse_start();
    wait_frames(f + 1);
  endtask

  task automatic fill_mem(input logic ramp);
    for (int i = 0; i < 16; i++) mem[i] = ramp ? 8'(i) : 8'($urandom_range(0, 255));
  endtask

  initial begin
    int base;
    reset_n = 1'b0;
    start   = 1'b0;
    start1  = 1'b0;
    mem1    = 8'hA5;
    fill_mem(1'b1);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    run_frame(M_ONE);
    run_frame(M_TOGGLE);
    fill_mem(1'b0);
    run_frame(M_STALL);

    // second start in the middle of a frame must be ignored
    mode = M_ONE;
    fill_mem(1'b0);
    base = hs_count;
    pulse_start();
    wait_hs(base + 5);
    pulse_start();
    wait_frames(4);

    // reset mid-frame, then a fresh frame from address 0
    fill_mem(1'b1);
    base = hs_count;
    pulse_start();
    wait_hs(base + 6);
    @(posedge clk); #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    run_frame(M_ONE);

    for (int r = 0; r < 4; r++) begin
      fill_mem(1'b0);
      run_frame(M_RAND);
    end

    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (8) @(posedge clk);

    #1 final_req = 1'b1;
    for (int k = 0; k < 10 && !final_ack; k++) @(posedge clk);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/output_bram_reader.md
OUTPUT_BRAM_READER -- requirements
Module: output_bram_reader

Interface
REQ-001 Parameter IMG_WIDTH, default 192, pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 251, lines per frame.
REQ-003 Parameter ADDR_W, default 16, BRAM address width; SHALL satisfy 2**ADDR_W >= IMG_WIDTH*IMG_HEIGHT.
REQ-004 clka  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 start  input  1  one-cycle request to read out one full frame.
REQ-007 busy  output  1  high from start acceptance until done_rd.
REQ-008 done_rd  output  1  one-cycle pulse after the final pixel handshake.
REQ-009 ena_rd  output  1  BRAM port enable; read-only port, no write enable driven.
REQ-010 addra_rd  output  ADDR_W  BRAM read address, raster order.
REQ-011 douta_rd  input  8  BRAM read data, valid exactly 1 cycle after an ena_rd cycle.
REQ-012 m_data  output  8  streamed pixel.
REQ-013 m_valid  output  1  m_data is valid.
REQ-014 m_ready  input  1  downstream accepts; transfer occurs when m_valid and m_ready are both high at a rising edge.
REQ-015 m_eol  output  1  qualifies m_data as the last pixel of a line (x = IMG_WIDTH-1).
REQ-016 m_eof  output  1  qualifies m_data as the last pixel of the frame; always coincides with m_eol.

Function
REQ-017 FSM states are IDLE, READ, DRAIN, and DONE.
REQ-018 IDLE -> READ when start is sampled high; start is ignored in every state other than IDLE.
REQ-019 In READ, ena_rd is asserted with addresses 0 .. IMG_WIDTH*IMG_HEIGHT-1 in order, each exactly once; addra_rd never exceeds IMG_WIDTH*IMG_HEIGHT-1.
REQ-020 A read is issued only while (FIFO occupancy + reads in flight) < 2, so no pixel is lost or duplicated under any m_ready pattern.
REQ-021 READ -> DRAIN in the cycle after the last address is issued; DRAIN -> DONE on the handshake of the m_eof pixel; DONE -> IDLE unconditionally after 1 cycle, with done_rd high for that cycle.
REQ-022 Latency: when start is sampled at edge E0, ena_rd=1 with addra_rd=0 in the cycle after E0, and m_valid rises after edge E0+2.
REQ-023 With m_ready held high, the block transfers one pixel per cycle; a full frame completes in IMG_WIDTH*IMG_HEIGHT+2 cycles from start to the last handshake.
REQ-024 While m_valid is high and m_ready is low, m_data, m_eol, and m_eof remain stable.
REQ-025 The x/y counters wrap: x goes 0..IMG_WIDTH-1, then returns to 0 and y increments; m_eol/m_eof are derived from the pixel's own coordinates, carried through the FIFO, and not from the issue counters.
REQ-026 For a 1x1 frame, the single pixel has m_eol=1 and m_eof=1.

Reset
REQ-027 While reset=0: state=IDLE, busy=0, done_rd=0, ena_rd=0, addra_rd=0, m_valid=0, m_data=0, m_eol=0, m_eof=0, and the FIFO is empty.
REQ-028 Asserting reset mid-frame aborts immediately with no done_rd pulse; after release, the block waits in IDLE for a new start, and the next frame restarts at address 0.

Structure
REQ-029 The shared package sobel_pkg holds PIX_W=8, the default IMG_WIDTH/IMG_HEIGHT, and the pixel-count/address-width constants; the writer-side blocks also use it.
REQ-030 The 2-entry FIFO is a single sub-module, pixel_skid_fifo (10-bit entry = data+eol+eof), with push/pop, full/empty, and the same reset.

Verification
REQ-031 IMG_WIDTH=4, IMG_HEIGHT=3, BRAM[i]=i, m_ready=1 -> 12 pixels 0x00..0x0B in order, m_eol on 3/7/11, m_eof on 11 only, done_rd 1 cycle after that handshake, 14 cycles from start to last handshake.
REQ-032 Same frame, m_ready toggles 1,0,1,0 -> identical data sequence, no drop or duplicate, data stable during every stalled cycle.
REQ-033 m_ready held low for 10 cycles after the first m_valid -> at most 2 reads outstanding, addra_rd frozen, stream resumes with the correct next pixel.
REQ-034 start pulsed again at pixel 5 of a 4x3 frame -> ignored; exactly 12 pixels and one done_rd result.
REQ-035 reset=0 for 2 cycles at pixel 6, then start -> all outputs at reset values during reset, no done_rd pulse, new frame begins at address 0 with pixel 0x00.
REQ-036 IMG_WIDTH=1, IMG_HEIGHT=1, BRAM[0]=0xA5 -> one pixel 0xA5 with m_eol=m_eof=1, followed by done_rd.
